// File: rtl/ysyx_23060203_ifu_pkg.sv
// Shared definitions for the fetch stage: RV32 major opcodes, the IFU state
// encoding and simulation-only performance event ids.
package ysyx_23060203_ifu_pkg;

  localparam int unsigned XLEN = 32;

  // inst[6:2] major opcodes
  typedef enum logic [4:0] {
    OP_LOAD     = 5'b00000,
    OP_MISC_MEM = 5'b00011,
    OP_IMM      = 5'b00100,
    OP_AUIPC    = 5'b00101,
    OP_STORE    = 5'b01000,
    OP_OP       = 5'b01100,
    OP_LUI      = 5'b01101,
    OP_BRANCH   = 5'b11000,
    OP_JALR     = 5'b11001,
    OP_JAL      = 5'b11011,
    OP_SYSTEM   = 5'b11100
  } opcode_e;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_OUT  = 2'd2
  } ifu_state_e;

  // Performance event ids, one bit each in perf_event
  localparam int unsigned PERF_IFU_FETCH = 0;
  localparam int unsigned PERF_IFU_DROP  = 1;
  localparam int unsigned PERF_NUM       = 2;

endpackage

// File: rtl/ysyx_23060203_bpu.sv
// Static next-PC predictor: backward conditional branches (inst[31] set) are
// predicted taken to pc+imm_b, everything else falls through to pc+4.
// Ports: pc, inst in; npc out (combinational).
module ysyx_23060203_bpu
  import ysyx_23060203_ifu_pkg::*;
(
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] npc
);

  logic [XLEN-1:0] imm_b;
  logic            taken;
  logic            unused_inst;

  assign imm_b = {{(XLEN-12){inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
  assign taken = (inst[6:2] == OP_BRANCH) & inst[31];
  assign npc   = pc + (taken ? imm_b : XLEN'(4));

  assign unused_inst = ^{inst[24:12], inst[1:0]};

endmodule

// File: rtl/ysyx_23060203_ifu.sv
// Instruction fetch unit: one read per PC on an AXI4-Lite-style read channel,
// {pc, inst} presented to decode over valid/ready, static next-PC prediction,
// and redirect handling from decode (jump) and execute (exu, higher priority).
// Ports: clock/reset; jump_*/exu_* redirects; ifu_ar*/ifu_r* read channel;
// out_valid/out_ready/out_pc/out_inst to decode.
module ysyx_23060203_ifu
  import ysyx_23060203_ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h3000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        jump_flush,
  input  logic [31:0] jump_dnpc,
  input  logic        exu_flush,
  input  logic [31:0] exu_dnpc,
  output logic [31:0] ifu_araddr,
  output logic        ifu_arvalid,
  input  logic        ifu_arready,
  input  logic [31:0] ifu_rdata,
  input  logic [1:0]  ifu_rresp,
  input  logic        ifu_rvalid,
  output logic        ifu_rready,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst
);

  ifu_state_e  state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic [31:0] inst, inst_nxt;
  logic [31:0] pend_pc, pend_pc_nxt;
  logic        drop, drop_nxt;
  logic        redir_pend, redir_pend_nxt;
  logic        redirect;
  logic [31:0] rtarget;
  logic [31:0] npc;
  logic        bubble;
  logic        unused_rresp;

  assign redirect = exu_flush | jump_flush;
  assign rtarget  = exu_flush ? exu_dnpc : jump_dnpc;

  // drop kept set alongside redir_pend marks the owed bubble cycle in S_REQ
  assign bubble = redir_pend & drop;

  assign ifu_araddr = pc;
  assign out_pc     = pc;
  assign out_inst   = inst;

  assign unused_rresp = ^ifu_rresp;

  ysyx_23060203_bpu u_bpu (
    .pc  (pc),
    .inst(inst),
    .npc (npc)
  );

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= S_REQ;
      pc         <= RESET_PC;
      inst       <= '0;
      pend_pc    <= '0;
      drop       <= 1'b0;
      redir_pend <= 1'b0;
    end else begin
      state      <= state_nxt;
      pc         <= pc_nxt;
      inst       <= inst_nxt;
      pend_pc    <= pend_pc_nxt;
      drop       <= drop_nxt;
      redir_pend <= redir_pend_nxt;
    end
  end

  // Next state and handshake outputs
  always_comb begin
    state_nxt      = state;
    pc_nxt         = pc;
    inst_nxt       = inst;
    pend_pc_nxt    = pend_pc;
    drop_nxt       = drop;
    redir_pend_nxt = redir_pend;
    ifu_arvalid    = 1'b0;
    ifu_rready     = 1'b0;
    out_valid      = 1'b0;

    case (state)
      S_REQ: begin
        if (bubble) begin
          // Retarget before raising arvalid on the new address
          pc_nxt         = redirect ? rtarget : pend_pc;
          redir_pend_nxt = 1'b0;
          drop_nxt       = 1'b0;
        end else begin
          ifu_arvalid = 1'b1;
          // araddr must hold while arvalid is up, so the redirect is parked
          if (redirect) begin
            redir_pend_nxt = 1'b1;
            pend_pc_nxt    = rtarget;
          end
          if (ifu_arready) begin
            state_nxt = S_WAIT;
            if (redirect | redir_pend) drop_nxt = 1'b1;
          end
        end
      end

      S_WAIT: begin
        ifu_rready = 1'b1;
        if (ifu_rvalid) begin
          state_nxt = S_REQ;
          if (redirect) begin
            pc_nxt         = rtarget;
            drop_nxt       = 1'b0;
            redir_pend_nxt = 1'b0;
          end else if (drop) begin
            drop_nxt = redir_pend;
          end else begin
            inst_nxt  = ifu_rdata;
            state_nxt = S_OUT;
          end
        end else if (redirect) begin
          pc_nxt         = rtarget;
          drop_nxt       = 1'b1;
          redir_pend_nxt = 1'b0;
        end
      end

      S_OUT: begin
        out_valid = ~redirect;
        if (redirect) begin
          pc_nxt    = rtarget;
          state_nxt = S_REQ;
        end else if (out_ready) begin
          pc_nxt    = npc;
          state_nxt = S_REQ;
        end
      end

      default: state_nxt = S_REQ;
    endcase
  end

`ifndef SYNTHESIS
  // Simulation-only fetch/drop/error event counters
  logic [PERF_NUM-1:0] perf_event;
  logic [31:0]         perf_cnt_fetch;
  logic [31:0]         perf_cnt_drop;
  logic [31:0]         rresp_err_cnt;
  logic                r_fire;

  assign r_fire                     = (state == S_WAIT) & ifu_rvalid;
  assign perf_event[PERF_IFU_FETCH] = r_fire & ~drop & ~redirect;
  assign perf_event[PERF_IFU_DROP]  = r_fire & (drop | redirect);

  always_ff @(posedge clock) begin
    if (reset) begin
      perf_cnt_fetch <= '0;
      perf_cnt_drop  <= '0;
      rresp_err_cnt  <= '0;
    end else begin
      if (perf_event[PERF_IFU_FETCH]) perf_cnt_fetch <= perf_cnt_fetch + 32'd1;
      if (perf_event[PERF_IFU_DROP])  perf_cnt_drop  <= perf_cnt_drop + 32'd1;
      if (r_fire && (ifu_rresp != 2'b00)) rresp_err_cnt <= rresp_err_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ysyx_23060203_ifu.sv
// Scoreboard bench for ysyx_23060203_ifu: tests push expected fetch addresses
// and decode transactions; a monitor pops and compares on each handshake.
module tb_ysyx_23060203_ifu;

  localparam logic [31:0] RPC = 32'h3000_0000;
  localparam logic [31:0] NOP = 32'h0010_0093;  // addi x1, x0, 1

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } out_t;

  logic        clock, reset;
  logic        jump_flush, exu_flush;
  logic [31:0] jump_dnpc, exu_dnpc;
  logic [31:0] ifu_araddr, ifu_rdata;
  logic        ifu_arvalid, ifu_arready, ifu_rvalid, ifu_rready;
  logic [1:0]  ifu_rresp;
  logic        out_valid, out_ready;
  logic [31:0] out_pc, out_inst;

  logic [31:0] exp_ar[$];
  out_t        exp_out[$];
  logic [31:0] mem [logic [31:0]];

  int n_cmp, n_err;
  int ar_budget, ar_stall, r_lat_cfg;
  logic [1:0] resp_cfg;
  int cyc, r_fires, out_cyc_prev, out_cyc_last;

  ysyx_23060203_ifu #(.RESET_PC(RPC)) dut (
    .clock(clock), .reset(reset),
    .jump_flush(jump_flush), .jump_dnpc(jump_dnpc),
    .exu_flush(exu_flush), .exu_dnpc(exu_dnpc),
    .ifu_araddr(ifu_araddr), .ifu_arvalid(ifu_arvalid), .ifu_arready(ifu_arready),
    .ifu_rdata(ifu_rdata), .ifu_rresp(ifu_rresp), .ifu_rvalid(ifu_rvalid),
    .ifu_rready(ifu_rready),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : NOP;
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h want %08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Memory slave plus handshake monitor. Inputs change on negedge; the
  // handshakes the next posedge will see are sampled 2 time units later.
  initial begin : slave_monitor
    logic ar_f, r_f, rst_s, busy, pv_arv, pv_ard;
    logic [31:0] pv_addr, s_addr;
    int lat;
    out_t e;
    ar_f = 0; r_f = 0; rst_s = 1; busy = 0; pv_arv = 0; pv_ard = 0;
    pv_addr = '0; s_addr = '0; lat = 0;
    ifu_arready = 0; ifu_rvalid = 0; ifu_rdata = '0; ifu_rresp = 2'b00;
    forever begin
      @(negedge clock);
      if (rst_s) begin
        busy = 0; ifu_rvalid = 0; ar_f = 0; r_f = 0;
      end
      if (r_f) begin
        busy = 0; ifu_rvalid = 0;
      end
      if (ar_f) begin
        busy = 1; s_addr = pv_addr; lat = r_lat_cfg;
      end
      if (busy && !ifu_rvalid) begin
        if (lat == 0) begin
          ifu_rvalid = 1; ifu_rdata = mem_rd(s_addr); ifu_rresp = resp_cfg;
        end else lat--;
      end
      ifu_arready = 0;
      if (!busy && ifu_arvalid && ar_budget > 0) begin
        if (ar_stall > 0) ar_stall--;
        else ifu_arready = 1;
      end
      #2;
      cyc++;
      rst_s = reset;
      ar_f  = !reset && ifu_arvalid && ifu_arready;
      r_f   = !reset && ifu_rvalid && ifu_rready;
      if (!reset && pv_arv && !pv_ard) begin
        check32("arvalid_hold", 32'(ifu_arvalid), 32'd1);
        check32("araddr_hold", ifu_araddr, pv_addr);
      end
      if (ar_f) begin
        ar_budget--;
        if (exp_ar.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_ar: got %08h want none", ifu_araddr);
        end else check32("araddr", ifu_araddr, exp_ar.pop_front());
      end
      if (r_f) r_fires++;
      if (!reset && out_valid && out_ready) begin
        out_cyc_prev = out_cyc_last; out_cyc_last = cyc;
        if (exp_out.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_out: got pc %08h inst %08h want none", out_pc, out_inst);
        end else begin
          e = exp_out.pop_front();
          check32("out_pc", out_pc, e.pc);
          check32("out_inst", out_inst, e.inst);
        end
      end
      pv_arv = !reset && ifu_arvalid; pv_ard = ifu_arready; pv_addr = ifu_araddr;
    end
  end

  // Enter reset and clear all test state; returns mid-cycle while in reset
  task automatic start_test();
    @(negedge clock);
    reset = 1; jump_flush = 0; exu_flush = 0; out_ready = 1; ar_budget = 0;
    repeat (2) @(negedge clock);
    #3;
    mem.delete(); exp_ar.delete(); exp_out.delete();
    ar_stall = 0; r_lat_cfg = 0; resp_cfg = 2'b00; r_fires = 0;
  endtask

  // Leave reset and check the first post-reset cycle
  task automatic release_reset(input int budget);
    ar_budget = budget;
    @(negedge clock);
    reset = 0;
    #3;
    check32("rst_arvalid", 32'(ifu_arvalid), 32'd1);
    check32("rst_araddr", ifu_araddr, RPC);
    check32("rst_rready", 32'(ifu_rready), 32'd0);
    check32("rst_out_valid", 32'(out_valid), 32'd0);
  endtask

  task automatic wait_done(input string nm);
    int k;
    for (k = 0; k < 200; k++) begin
      @(negedge clock); #3;
      if (exp_ar.size() == 0 && exp_out.size() == 0) break;
    end
    n_cmp++;
    if (k == 200) begin
      n_err++;
      $display("FAIL %s_timeout: got %0d/%0d pending want 0/0", nm, exp_ar.size(), exp_out.size());
    end
    repeat (4) @(negedge clock);
  endtask

  task automatic wait_state(input string nm, input bit want_out);
    int k;
    for (k = 0; k < 60; k++) begin
      @(negedge clock); #3;
      if (want_out ? out_valid : ifu_rready) break;
    end
    n_cmp++;
    if (k == 60) begin
      n_err++;
      $display("FAIL %s_timeout: got none want %s", nm, want_out ? "out_valid" : "rready");
    end
  endtask

  initial begin : stim
    n_cmp = 0; n_err = 0; cyc = 0; r_fires = 0;
    out_cyc_prev = 0; out_cyc_last = 0;
    ar_budget = 0; ar_stall = 0; r_lat_cfg = 0; resp_cfg = 2'b00;
    reset = 1; jump_flush = 0; exu_flush = 0; jump_dnpc = '0; exu_dnpc = '0; out_ready = 1;

    // Sequential fetch, zero-latency memory, one instruction per 3 cycles
    start_test();
    exp_ar.push_back(32'h3000_0000); exp_ar.push_back(32'h3000_0004);
    exp_out.push_back(out_t'{32'h3000_0000, NOP});
    exp_out.push_back(out_t'{32'h3000_0004, NOP});
    release_reset(2);
    wait_done("seq");
    check32("throughput", 32'(out_cyc_last - out_cyc_prev), 32'd3);

    // Backward branch at +8 predicted taken to +4
    start_test();
    mem[32'h3000_0008] = 32'hFE00_0EE3;
    exp_ar.push_back(32'h3000_0000); exp_ar.push_back(32'h3000_0004);
    exp_ar.push_back(32'h3000_0008); exp_ar.push_back(32'h3000_0004);
    exp_out.push_back(out_t'{32'h3000_0000, NOP});
    exp_out.push_back(out_t'{32'h3000_0004, NOP});
    exp_out.push_back(out_t'{32'h3000_0008, 32'hFE00_0EE3});
    exp_out.push_back(out_t'{32'h3000_0004, NOP});
    release_reset(4);
    wait_done("bwd_branch");

    // Forward branch (inst[31]=0) falls through; error rresp still delivers data
    start_test();
    mem[32'h3000_0008] = 32'h0000_0463;
    resp_cfg = 2'b10;
    exp_ar.push_back(32'h3000_0000); exp_ar.push_back(32'h3000_0004);
    exp_ar.push_back(32'h3000_0008); exp_ar.push_back(32'h3000_000C);
    exp_out.push_back(out_t'{32'h3000_0000, NOP});
    exp_out.push_back(out_t'{32'h3000_0004, NOP});
    exp_out.push_back(out_t'{32'h3000_0008, 32'h0000_0463});
    exp_out.push_back(out_t'{32'h3000_000C, NOP});
    release_reset(4);
    wait_done("fwd_branch");

    // jump_flush while holding a wrong-path instruction in S_OUT
    start_test();
    mem[32'h3000_0000] = 32'hDEAD_0013;
    exp_ar.push_back(32'h3000_0000); exp_ar.push_back(32'h3000_0100);
    exp_out.push_back(out_t'{32'h3000_0100, NOP});
    out_ready = 0;
    release_reset(2);
    wait_state("out_hold", 1'b1);
    @(negedge clock);
    jump_flush = 1; jump_dnpc = 32'h3000_0100; out_ready = 1;
    #3 check32("flush_out_valid", 32'(out_valid), 32'd0);
    @(negedge clock);
    jump_flush = 0;
    wait_done("out_flush");

    // jump_flush during S_WAIT with a 5-cycle response delay
    start_test();
    r_lat_cfg = 5;
    exp_ar.push_back(32'h3000_0000); exp_ar.push_back(32'h3000_0040);
    exp_out.push_back(out_t'{32'h3000_0040, NOP});
    release_reset(2);
    wait_state("wait_rready", 1'b0);
    @(negedge clock);
    jump_flush = 1; jump_dnpc = 32'h3000_0040;
    @(negedge clock);
    jump_flush = 0;
    wait_done("wait_flush");
    check32("wait_flush_rfires", 32'(r_fires), 32'd2);

    // Redirect while the address phase is stalled for 4 cycles
    start_test();
    ar_stall = 4;
    exp_ar.push_back(32'h3000_0000); exp_ar.push_back(32'h3000_0500);
    exp_out.push_back(out_t'{32'h3000_0500, NOP});
    release_reset(2);
    @(negedge clock);
    jump_flush = 1; jump_dnpc = 32'h3000_0500;
    #3 check32("stall_araddr", ifu_araddr, RPC);
    @(negedge clock);
    jump_flush = 0;
    wait_done("req_flush");
    check32("req_flush_rfires", 32'(r_fires), 32'd2);

    // exu_flush beats jump_flush; then decode stalls 10 cycles
    start_test();
    mem[32'h3000_0200] = 32'h1234_5678;
    exp_ar.push_back(32'h3000_0000); exp_ar.push_back(32'h3000_0200);
    exp_out.push_back(out_t'{32'h3000_0200, 32'h1234_5678});
    out_ready = 0;
    release_reset(2);
    wait_state("prio_out", 1'b1);
    @(negedge clock);
    exu_flush = 1; exu_dnpc = 32'h3000_0200;
    jump_flush = 1; jump_dnpc = 32'h3000_0300; out_ready = 1;
    #3 check32("prio_out_valid", 32'(out_valid), 32'd0);
    @(negedge clock);
    exu_flush = 0; jump_flush = 0; out_ready = 0;
    wait_state("prio_refetch", 1'b1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clock); #3;
      check32("hold_valid", 32'(out_valid), 32'd1);
      check32("hold_pc", out_pc, 32'h3000_0200);
      check32("hold_inst", out_inst, 32'h1234_5678);
    end
    @(negedge clock);
    out_ready = 1;
    wait_done("prio");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: got no end of test want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
